// File: rtl/proc_run_ctrl.sv
// Host-side run controller: pulses req to the processor, waits for done under a
// watchdog, and reports run length, timeout status and completed-run count.
module proc_run_ctrl #(
  parameter int unsigned CW      = 16,
  parameter int unsigned REQ_LEN = 1,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          done,
  output logic          req,
  output logic          busy,
  output logic          finished,
  output logic          timed_out,
  output logic [CW-1:0] cycles,
  output logic [7:0]    runs
);

  localparam int unsigned RW = (REQ_LEN > 1) ? $clog2(REQ_LEN) : 1;
  localparam logic [RW-1:0] RQ_LAST = RW'(REQ_LEN - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [RW-1:0] rq, rq_d;
  logic          req_d, busy_d, finished_d, timed_out_d;
  logic [CW-1:0] cycles_d;
  logic [7:0]    runs_d;

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      rq        <= '0;
      req       <= 1'b0;
      busy      <= 1'b0;
      finished  <= 1'b0;
      timed_out <= 1'b0;
      cycles    <= '0;
      runs      <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      rq        <= rq_d;
      req       <= req_d;
      busy      <= busy_d;
      finished  <= finished_d;
      timed_out <= timed_out_d;
      cycles    <= cycles_d;
      runs      <= runs_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    rq_d        = rq;
    req_d       = req;
    timed_out_d = timed_out;
    cycles_d    = cycles;
    runs_d      = runs;

    case (state)
      IDLE: begin
        if (start) begin
          state_d     = REQ;
          cnt_d       = '0;
          rq_d        = '0;
          req_d       = 1'b1;
          timed_out_d = 1'b0;
        end
      end
      REQ: begin
        // done may still be high from the previous program, so it is not looked at here
        cnt_d = cnt + 1'b1;
        if (rq == RQ_LAST) begin
          state_d = WAIT;
          req_d   = 1'b0;
        end else begin
          rq_d = rq + 1'b1;
        end
      end
      WAIT: begin
        if (done) begin
          cycles_d = cnt;
          runs_d   = runs + 8'd1;
          state_d  = FIN;
        end else if (cnt == CNT_MAX) begin
          cycles_d    = CNT_MAX;
          timed_out_d = 1'b1;
          state_d     = FIN;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    finished_d = (state_d == FIN);
  end

endmodule

// File: tb/tb_proc_run_ctrl.sv
// Bench for proc_run_ctrl: two parameterisations share stimulus and are each
// tracked by a timeline-based reference model, plus a directed vector table.
module tb_proc_run_ctrl;

  localparam int unsigned A_CW = 16, A_RL = 1, A_TMO = 8;
  localparam int unsigned B_CW = 10, B_RL = 3, B_TMO = 20;

  logic clk, reset, start, done;
  logic a_req, a_busy, a_fin, a_to;
  logic [A_CW-1:0] a_cycles;
  logic [7:0] a_runs;
  logic b_req, b_busy, b_fin, b_to;
  logic [B_CW-1:0] b_cycles;
  logic [7:0] b_runs;

  int checks = 0;
  int failures = 0;
  bit mon_en = 0;
  int t = 0;

  proc_run_ctrl #(.CW(A_CW), .REQ_LEN(A_RL), .TIMEOUT(A_TMO)) dut_a (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .req(a_req), .busy(a_busy), .finished(a_fin), .timed_out(a_to),
    .cycles(a_cycles), .runs(a_runs));

  proc_run_ctrl #(.CW(B_CW), .REQ_LEN(B_RL), .TIMEOUT(B_TMO)) dut_b (
    .clk(clk), .reset(reset), .start(start), .done(done),
    .req(b_req), .busy(b_busy), .finished(b_fin), .timed_out(b_to),
    .cycles(b_cycles), .runs(b_runs));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a run is described by its acceptance edge e0; every
  // output follows from the elapsed edge count since then.
  typedef struct {
    logic active;
    logic fin;
    int   e0;
    logic req;
    logic busy;
    logic finished;
    logic to;
    int   cycles;
    int   runs;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mstep(mdl_t m, logic st, logic dn, int now, int rl, int tmo);
    int el;
    if (m.fin) begin
      m.fin    = 1'b0;
      m.active = 1'b0;
    end else if (!m.active) begin
      if (st) begin
        m.active = 1'b1;
        m.e0     = now;
        m.to     = 1'b0;
      end
    end else begin
      el = now - m.e0;
      if (el >= rl + 1 && dn) begin
        m.cycles = el - 1;
        m.runs   = (m.runs + 1) % 256;
        m.fin    = 1'b1;
      end else if (el == tmo + 1) begin
        m.cycles = tmo;
        m.to     = 1'b1;
        m.fin    = 1'b1;
      end
    end
    m.finished = m.fin;
    m.busy     = m.active;
    m.req      = m.active && !m.fin && ((now - m.e0) < rl);
    return m;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ma = '{default: 0};
      mb = '{default: 0};
    end else begin
      ma = mstep(ma, start, done, t, A_RL, A_TMO);
      mb = mstep(mb, start, done, t, B_RL, B_TMO);
      t  = t + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Continuous comparison of both instances against the model
  always @(negedge clk) begin
    if (mon_en) begin
      chk("a_req", 32'(a_req), 32'(ma.req));
      chk("a_busy", 32'(a_busy), 32'(ma.busy));
      chk("a_finished", 32'(a_fin), 32'(ma.finished));
      chk("a_timed_out", 32'(a_to), 32'(ma.to));
      chk("a_cycles", 32'(a_cycles), 32'(ma.cycles));
      chk("a_runs", 32'(a_runs), 32'(ma.runs));
      chk("b_req", 32'(b_req), 32'(mb.req));
      chk("b_busy", 32'(b_busy), 32'(mb.busy));
      chk("b_finished", 32'(b_fin), 32'(mb.finished));
      chk("b_timed_out", 32'(b_to), 32'(mb.to));
      chk("b_cycles", 32'(b_cycles), 32'(mb.cycles));
      chk("b_runs", 32'(b_runs), 32'(mb.runs));
    end
  end

  typedef struct {
    logic st, dn;
    logic rq, bz, fn, to;
    int   cyc, rn;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic dn, logic rq, logic bz, logic fn, logic to,
                              int cyc, int rn);
    vec_t v;
    v.st = st; v.dn = dn; v.rq = rq; v.bz = bz; v.fn = fn; v.to = to;
    v.cyc = cyc; v.rn = rn;
    tbl.push_back(v);
  endfunction

  task automatic wait_both_idle(input string nm);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (!a_busy && !b_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk(nm, 32'(ok), 32'd1);
  endtask

  initial begin
    int nfin, nacc;
    logic prev_busy;

    // Expected dut_a outputs (REQ_LEN=1, TIMEOUT=8) after each edge
    add(1, 0, 1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 1, 0, 1, 1, 0, 6, 1);
    add(0, 0, 0, 0, 0, 0, 6, 1);
    add(1, 0, 1, 1, 0, 0, 6, 1);
    for (int i = 0; i < 8; i++) add(0, 0, 0, 1, 0, 0, 6, 1);
    add(0, 0, 0, 1, 1, 1, 8, 1);
    add(0, 0, 0, 0, 0, 1, 8, 1);
    add(1, 0, 1, 1, 0, 0, 8, 1);
    add(0, 1, 0, 1, 0, 0, 8, 1);
    add(0, 1, 0, 1, 1, 0, 1, 2);
    add(1, 0, 0, 0, 0, 0, 1, 2);
    add(1, 0, 1, 1, 0, 0, 1, 2);
    add(0, 0, 0, 1, 0, 0, 1, 2);

    // Power-up reset held two cycles with start high
    reset = 1'b1;
    start = 1'b1;
    done  = 1'b0;
    #1 reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("por_a_req", 32'(a_req), 32'd0);
    chk("por_a_busy", 32'(a_busy), 32'd0);
    chk("por_b_req", 32'(b_req), 32'd0);
    chk("por_b_busy", 32'(b_busy), 32'd0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].st;
      done  = tbl[i].dn;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_req", i), 32'(a_req), 32'(tbl[i].rq));
      chk($sformatf("tbl%0d_busy", i), 32'(a_busy), 32'(tbl[i].bz));
      chk($sformatf("tbl%0d_finished", i), 32'(a_fin), 32'(tbl[i].fn));
      chk($sformatf("tbl%0d_timed_out", i), 32'(a_to), 32'(tbl[i].to));
      chk($sformatf("tbl%0d_cycles", i), 32'(a_cycles), 32'(tbl[i].cyc));
      chk($sformatf("tbl%0d_runs", i), 32'(a_runs), 32'(tbl[i].rn));
    end

    // REQ_LEN=3 with done still high from before: done ignored during REQ
    start = 1'b0;
    done  = 1'b1;
    wait_both_idle("idle_before_rl3");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("rl3_req_e0", 32'(b_req), 32'd1);
    for (int k = 1; k < 3; k++) begin
      @(posedge clk); #1;
      chk($sformatf("rl3_req_e%0d", k), 32'(b_req), 32'd1);
      chk($sformatf("rl3_fin_e%0d", k), 32'(b_fin), 32'd0);
    end
    @(posedge clk); #1;
    chk("rl3_req_e3", 32'(b_req), 32'd0);
    chk("rl3_fin_e3", 32'(b_fin), 32'd0);
    @(posedge clk); #1;
    chk("rl3_fin_e4", 32'(b_fin), 32'd1);
    chk("rl3_cycles", 32'(b_cycles), 32'd3);
    chk("rl3_timed_out", 32'(b_to), 32'd0);

    // Asynchronous reset mid-run
    done = 1'b0;
    wait_both_idle("idle_before_arst");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("arst_pre_a_busy", 32'(a_busy), 32'd1);
    chk("arst_pre_b_req", 32'(b_req), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("arst_a_busy", 32'(a_busy), 32'd0);
    chk("arst_a_cycles", 32'(a_cycles), 32'd0);
    chk("arst_a_finished", 32'(a_fin), 32'd0);
    chk("arst_b_req", 32'(b_req), 32'd0);
    chk("arst_b_busy", 32'(b_busy), 32'd0);
    chk("arst_b_cycles", 32'(b_cycles), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // 257 back-to-back runs with start tied high
    start = 1'b1;
    done  = 1'b1;
    nfin = 0;
    nacc = 0;
    prev_busy = a_busy;
    for (int i = 0; i < 2000; i++) begin
      @(posedge clk); #1;
      if (a_fin) nfin++;
      if (a_busy && !prev_busy) nacc++;
      prev_busy = a_busy;
      if (nfin == 257) break;
    end
    start = 1'b0;
    chk("wrap_finished_count", 32'(nfin), 32'd257);
    chk("wrap_accept_count", 32'(nacc), 32'd257);
    chk("wrap_runs", 32'(a_runs), 32'd1);

    // Randomised traffic with occasional asynchronous resets
    for (int blk = 0; blk < 15; blk++) begin
      int dprob;
      dprob = (blk % 3 == 0) ? 40 : ((blk % 3 == 1) ? 6 : 2);
      for (int i = 0; i < 200; i++) begin
        start = ($urandom_range(0, 3) == 0);
        done  = ($urandom_range(0, dprob - 1) == 0);
        if ($urandom_range(0, 399) == 0) begin
          #1 reset = 1'b0;
          @(posedge clk); #1;
          reset = 1'b1;
        end else begin
          @(posedge clk); #1;
        end
      end
    end

    start = 1'b0;
    done  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
